// File: rtl/switch_debounce.sv
// switch_debounce: per-bit synchronizer plus stability-counter debounce
// for the slide switches, with registered rise/fall strobes.
module switch_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] done;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: only sync_q[0] ever samples the raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // A bit is done when it has differed for the full window.
  always_comb begin
    diff = s ^ sw_clean;
    done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      done[i] = diff[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Stability counters: cleared on agreement or on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!diff[i] || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Clean level and strobes update together in one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_clean   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      any_change <= 1'b0;
    end else begin
      sw_clean   <= sw_clean ^ done;
      sw_rise    <= done & s;
      sw_fall    <= done & ~s;
      any_change <= |done;
    end
  end

endmodule
